// File: rtl/tx_frame_writer_pkg.sv
// Shared definitions for the TX frame writer: Gray-coded FSM states, default sync byte, frame tags.
// TX_FRAME_CHECKSUM_EN adds the CSUM state.
package tx_frame_writer_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Tags mirror the host command codes so replies can be matched to requests.
  localparam logic [7:0] TAG_CCD_LINE = 8'h01;
  localparam logic [7:0] TAG_ADC_BURST = 8'h02;
  localparam logic [7:0] TAG_STATUS = 8'h03;
  localparam logic [7:0] TAG_ECHO = 8'h7E;

  // Gray sequence along the normal frame path, one bit flip per step.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0000,
    ST_SYNC      = 4'b0001,
    ST_TAG       = 4'b0011,
    ST_LEN_LO    = 4'b0010,
    ST_LEN_HI    = 4'b0110,
    ST_WAIT_WORD = 4'b0111,
    ST_PAY_BYTE  = 4'b0101,
`ifdef TX_FRAME_CHECKSUM_EN
    ST_CSUM      = 4'b0100,
`endif
    ST_DONE      = 4'b1100
  } state_t;

  function automatic logic is_summed(state_t s);
    return (s == ST_TAG) || (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_PAY_BYTE);
  endfunction

endpackage

// File: rtl/tx_frame_writer_if.sv
// Upstream word stream and TX FIFO write port of the frame writer.
// slave = the writer itself, master = whatever drives it.
interface tx_frame_writer_if #(parameter int DATA_BYTES = 2);
  logic                    in_valid;
  logic [8*DATA_BYTES-1:0] in_data;
  logic                    in_ready;
  logic [7:0]              fifo_wdata;
  logic                    fifo_winc;
  logic                    fifo_wfull;

  modport slave  (input in_valid, in_data, fifo_wfull,
                  output in_ready, fifo_wdata, fifo_winc);
  modport master (output in_valid, in_data, fifo_wfull,
                  input in_ready, fifo_wdata, fifo_winc);
endinterface

// File: rtl/tx_byte_emit.sv
// Byte-to-FIFO handshake: presents the FSM's current byte and strobes winc only when not full.
// Purely combinational; the FSM holds the byte steady while stalled.
module tx_byte_emit (
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_taken,
  input  logic       fifo_wfull,
  output logic [7:0] fifo_wdata,
  output logic       fifo_winc
);
  logic w_winc;

  assign w_winc     = byte_valid & ~fifo_wfull;
  assign fifo_winc  = w_winc;
  assign byte_taken = w_winc;
  assign fifo_wdata = byte_valid ? byte_data : 8'h00;
endmodule

// File: rtl/tx_frame_writer.sv
// Frames a burst of upstream words as SYNC, TAG, LEN_LO, LEN_HI, payload (LSB first) [, CSUM].
// Define TX_FRAME_CHECKSUM_EN to append the modulo-256 checksum byte.
module tx_frame_writer
  import tx_frame_writer_pkg::*;
#(
  parameter int         DATA_BYTES = 2,
  parameter int         LEN_WIDTH  = 16,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           tag,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 busy,
  output logic                 done,
  tx_frame_writer_if.slave     bus
);
  localparam int SHW = 8 * DATA_BYTES;
  localparam int BIW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int LW  = (LEN_WIDTH < 16) ? LEN_WIDTH : 16;

`ifdef TX_FRAME_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t               r_state, w_next;
  logic [7:0]           r_tag;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_words;
  logic [SHW-1:0]       r_shift;
  logic [BIW-1:0]       r_bidx;
`ifdef TX_FRAME_CHECKSUM_EN
  logic [7:0]           r_csum;
`endif

  logic       w_byte_valid, w_byte_taken, w_hs, w_last_byte;
  logic [7:0] w_byte_data;
  logic [15:0] w_len16;

  // Length field is always two bytes; narrower counters are zero-extended.
  assign w_len16     = 16'(r_len[LW-1:0]);
  assign w_hs        = (r_state == ST_WAIT_WORD) & bus.in_valid;
  assign w_last_byte = (r_bidx == BIW'(DATA_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_byte_valid = 1'b0;
    w_byte_data  = 8'h00;
    bus.in_ready = 1'b0;
    busy         = (r_state != ST_IDLE);
    done         = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_SYNC;
      ST_SYNC: begin
        w_byte_valid = 1'b1;
        w_byte_data  = SYNC_BYTE;
        if (w_byte_taken) w_next = ST_TAG;
      end
      ST_TAG: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_tag;
        if (w_byte_taken) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        w_byte_valid = 1'b1;
        w_byte_data  = w_len16[7:0];
        if (w_byte_taken) w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        w_byte_valid = 1'b1;
        w_byte_data  = w_len16[15:8];
        if (w_byte_taken) w_next = (r_len == '0) ? ST_TAIL : ST_WAIT_WORD;
      end
      ST_WAIT_WORD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_PAY_BYTE;
      end
      ST_PAY_BYTE: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_shift[7:0];
        if (w_byte_taken && w_last_byte)
          w_next = (r_words != '0) ? ST_WAIT_WORD : ST_TAIL;
      end
`ifdef TX_FRAME_CHECKSUM_EN
      ST_CSUM: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_csum;
        if (w_byte_taken) w_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag   <= 8'h00;
      r_len   <= '0;
      r_words <= '0;
      r_shift <= '0;
      r_bidx  <= '0;
`ifdef TX_FRAME_CHECKSUM_EN
      r_csum  <= 8'h00;
`endif
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_tag   <= tag;
        r_len   <= length;
        r_words <= length;
`ifdef TX_FRAME_CHECKSUM_EN
        r_csum  <= 8'h00;
`endif
      end
      if (w_hs) begin
        r_shift <= bus.in_data;
        r_bidx  <= '0;
        r_words <= r_words - 1'b1;
      end
      if (r_state == ST_PAY_BYTE && w_byte_taken) begin
        r_shift <= r_shift >> 8;
        r_bidx  <= r_bidx + 1'b1;
      end
`ifdef TX_FRAME_CHECKSUM_EN
      if (w_byte_taken && is_summed(r_state)) r_csum <= r_csum + w_byte_data;
`endif
    end
  end

  tx_byte_emit u_emit (
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .byte_taken (w_byte_taken),
    .fifo_wfull (bus.fifo_wfull),
    .fifo_wdata (bus.fifo_wdata),
    .fifo_winc  (bus.fifo_winc)
  );

endmodule

// File: tb/tb_tx_frame_writer.sv
// Directed bench for tx_frame_writer: table of frames plus hand-written reset sequence.
`timescale 1ns/1ps
module tb_tx_frame_writer;
  localparam int DB = 2;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic [7:0]    tag;
  logic [LW-1:0] length;

  tx_frame_writer_if #(.DATA_BYTES(DB)) bus();

  tx_frame_writer #(.DATA_BYTES(DB), .LEN_WIDTH(LW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .tag(tag), .length(length),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic [15:0] len;
    logic [47:0] words;    // word i at [47-16*i -: 16]
    int          gap;
    int          stall_at; // frame byte index to hold wfull on, -1 = none
    int          restart;
    logic [79:0] exp;      // byte i at [79-8*i -: 8]
    int          n;        // bytes excluding checksum
    logic [7:0]  cs;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] got[$];
  int fb = 0, wfull_viol = 0, hdr_rdy = 0, rdy_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (bus.fifo_winc) begin
      got.push_back(bus.fifo_wdata);
      if (bus.fifo_wfull) wfull_viol <= wfull_viol + 1;
    end
    if (!busy) fb <= 0;
    else if (bus.fifo_winc) fb <= fb + 1;
    if (bus.in_ready) begin
      rdy_cnt <= rdy_cnt + 1;
      if (fb < 4) hdr_rdy <= hdr_rdy + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic feed(input vec_t v);
    logic hs;
    int t;
    for (int w = 0; w < int'(v.len); w++) begin
      if (v.gap > 0) begin
        repeat (v.gap) @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v.words[47-16*w -: 16];
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 2000) begin
        @(negedge clk);
        hs = bus.in_ready;
        @(posedge clk);
        t++;
      end
      #1 bus.in_valid = 1'b0;
      check("feed_handshake", {31'd0, hs}, 32'd1);
    end
  endtask

  task automatic side(input vec_t v);
    int t;
    if (v.stall_at >= 0) begin
      t = 0;
      while (fb < v.stall_at && t < 1000) begin
        @(posedge clk);
        t++;
      end
      #1 bus.fifo_wfull = 1'b1;
      repeat (5) begin
        @(negedge clk);
        check("stall_winc", {31'd0, bus.fifo_winc}, 32'd0);
        check("stall_wdata", {24'd0, bus.fifo_wdata}, {24'd0, v.exp[79-8*v.stall_at -: 8]});
      end
      @(posedge clk);
      #1 bus.fifo_wfull = 1'b0;
    end
    if (v.restart != 0) begin
      t = 0;
      while (fb < 3 && t < 1000) begin
        @(posedge clk);
        t++;
      end
      #1;
      start = 1'b1; tag = 8'hEE; length = 16'd5;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int base, d0, r0, h0, t, n;
    logic [7:0] e[$];
    for (int i = 0; i < v.n; i++) e.push_back(v.exp[79-8*i -: 8]);
`ifdef TX_FRAME_CHECKSUM_EN
    e.push_back(v.cs);
`endif
    base = got.size(); d0 = done_cnt; r0 = rdy_cnt; h0 = hdr_rdy;
    start = 1'b1; tag = v.tag; length = v.len;
    @(posedge clk);
    #1 start = 1'b0;
    fork
      feed(v);
      side(v);
    join
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    n = got.size() - base;
    check({name, "_byte_count"}, n, e.size());
    for (int i = 0; i < e.size() && i < n; i++)
      check($sformatf("%s_byte%0d", name, i), {24'd0, got[base+i]}, {24'd0, e[i]});
    check({name, "_ready_in_header"}, hdr_rdy - h0, 0);
    if (v.len == 16'd0) check({name, "_ready_len0"}, rdy_cnt - r0, 0);
    check({name, "_winc_while_full"}, wfull_viol, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, t;
    vecs[0] = '{tag:8'h01, len:16'd2, words:48'h1234_ABCD_0000, gap:0, stall_at:-1, restart:0,
                exp:80'hA5_01_02_00_34_12_CD_AB_00_00, n:8, cs:8'hC1};
    vecs[1] = '{tag:8'h7E, len:16'd0, words:48'h0, gap:0, stall_at:-1, restart:0,
                exp:80'hA5_7E_00_00_00_00_00_00_00_00, n:4, cs:8'h7E};
    vecs[2] = '{tag:8'h02, len:16'd1, words:48'hBEEF_0000_0000, gap:0, stall_at:2, restart:0,
                exp:80'hA5_02_01_00_EF_BE_00_00_00_00, n:6, cs:8'hB0};
    vecs[3] = '{tag:8'h03, len:16'd3, words:48'h0102_0304_0506, gap:10, stall_at:-1, restart:0,
                exp:80'hA5_03_03_00_02_01_04_03_06_05, n:10, cs:8'h1B};
    vecs[4] = '{tag:8'h04, len:16'd1, words:48'h00FF_0000_0000, gap:0, stall_at:-1, restart:1,
                exp:80'hA5_04_01_00_FF_00_00_00_00_00, n:6, cs:8'h04};

    rst = 1'b1; start = 1'b0; tag = 8'h00; length = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.fifo_wfull = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("reset_winc", {31'd0, bus.fifo_winc}, 32'd0);
    check("reset_wdata", {24'd0, bus.fifo_wdata}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort a frame mid-payload, then check a clean frame follows.
    base = got.size();
    start = 1'b1; tag = 8'h02; length = 16'd1;
    @(posedge clk);
    #1 start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h5678;
    t = 0;
    while (fb < 5 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("rst_reached_payload", fb, 5);
    #1 rst = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_winc", {31'd0, bus.fifo_winc}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_wdata", {24'd0, bus.fifo_wdata}, 32'd0);
    check("midrst_bytes_written", got.size() - base, 6);
    repeat (2) @(posedge clk);
    #1;
    run_vec(vecs[0], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_frame_writer.md
Name: tx_frame_writer

Overview:
- Writer side of the FPGA-to-host TX FIFO. The ft245 block drains that FIFO toward the FT232H.
- Converts a burst of N data words (CCD pixels, MCP3008 samples) into a framed byte stream and pushes it one byte per cycle into the fifo write port.
- Replaces the hand-coded per-byte write states in the controller.
- Frame layout: SYNC, TAG, LEN_LO, LEN_HI, payload bytes (LSB first per word), optional checksum.

Parameters:
- DATA_BYTES, 2, bytes per input word (1..4).
- LEN_WIDTH, 16, width of the word-count field. LEN_HI carries length[15:8]; upper bits are ignored if LEN_WIDTH exceeds 16.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock; the fifo write clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- tag  in  8  frame type/command echo; captured on start.
- length  in  LEN_WIDTH  payload word count; captured on start.
- in_valid  in  1  upstream word valid.
- in_data  in  8*DATA_BYTES  upstream word.
- in_ready  out  1  word accepted when in_valid & in_ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse, frame fully written.
- fifo_wdata  out  8  tx fifo write data.
- fifo_winc  out  1  tx fifo write strobe.
- fifo_wfull  in  1  tx fifo full.

Behaviour:
- Reset values (rst=1 at a clk edge): state=IDLE, in_ready=0, busy=0, done=0, fifo_winc=0, fifo_wdata=0, checksum=0, word counter=0.
- States: IDLE, SYNC, TAG, LEN_LO, LEN_HI, WAIT_WORD, PAY_BYTE, CSUM, DONE.
- Emitting states are SYNC, TAG, LEN_LO, LEN_HI, PAY_BYTE and CSUM. In these, fifo_wdata holds the current byte (stable while stalled) and fifo_winc = !fifo_wfull.
  - The state advances only on a cycle where fifo_winc=1.
  - fifo_winc is never asserted while fifo_wfull=1.
- IDLE:
  - start=1 at edge N captures tag/length, clears the checksum and goes to SYNC.
  - First fifo_winc (SYNC_BYTE) is at cycle N+1 if not full.
  - start outside IDLE is ignored (no queueing).
- Header path: SYNC -> TAG -> LEN_LO -> LEN_HI. After LEN_HI:
  - length==0 goes to CSUM (or DONE without the feature).
  - otherwise goes to WAIT_WORD.
- WAIT_WORD:
  - in_ready=1 only here.
  - On handshake: latch in_data into a shift register, set byte index=0, decrement words remaining, go to PAY_BYTE.
  - in_valid=0 holds the state indefinitely.
- PAY_BYTE:
  - Emits shift[7:0], then shifts right by 8.
  - After byte DATA_BYTES-1: words remaining>0 goes to WAIT_WORD; otherwise CSUM/DONE.
- Throughput: DATA_BYTES+1 cycles per word with no backpressure; the handshake cycle emits nothing.
- DONE: busy=1, done=1 for exactly one cycle, then IDLE.
- busy: 1 in every state except IDLE.
- Word counter is LEN_WIDTH bits; length=2^LEN_WIDTH-1 must work without wrap.
- Mid-frame reset: returns to IDLE next edge with fifo_winc=0. Bytes already written stay in the FIFO; the controller resets the FIFO alongside.
- Simultaneous events:
  - in_valid asserted during header states is not accepted (in_ready=0).
  - fifo_wfull rising at the same edge a byte is being written: that write has already occurred, since winc was evaluated on the pre-edge wfull.

Optional Feature:
- TX_FRAME_CHECKSUM_EN defined:
  - CSUM state is present.
  - Emits the 8-bit modulo-256 sum of TAG, LEN_LO, LEN_HI and all payload bytes. SYNC is excluded.
  - The sum is accumulated on each fifo_winc of those bytes.
- Undefined: no CSUM state, no checksum register; the frame ends after the last payload byte (or LEN_HI when length=0).

Decomposition:
- Shared header tx_frame.vh holds:
  - state localparams (Gray coded, matching the controller's style of encoding);
  - default SYNC_BYTE;
  - the frame-tag values that mirror the existing command codes.
- One natural sub-module: tx_byte_emit, which holds the byte and implements the winc/wfull handshake.
  - Interface: byte_valid, byte_data, byte_taken.
  - It keeps the main FSM free of fifo timing.

Test Plan:
- CHECKSUM_EN, tag=0x01, length=2, words 0x1234, 0xABCD, wfull=0:
  - FIFO receives A5 01 02 00 34 12 CD AB C1.
  - done pulses once; busy=0 after.
- length=0, tag=0x7E, checksum on: bytes A5 7E 00 00 7E, in_ready never asserted.
- wfull held 1 for 5 cycles during LEN_LO:
  - fifo_winc=0 and fifo_wdata stable throughout.
  - Stream is unchanged afterwards with no dup/drop.
- in_valid gapped (1 word every 10 cycles, length=3, DATA_BYTES=2): exactly 6 payload bytes in order; in_ready only in WAIT_WORD.
- start pulsed again mid-frame: ignored, single frame output.
- rst asserted after payload byte 1: winc=0 next cycle; a new start then produces a complete fresh frame beginning A5.
